// File: rtl/if_id_queue.sv
// Two-entry fetch/decode queue with JMP redirect; optional same-cycle bypass via IFID_BYPASS_EN.
// Latency: write to id_valid is 1 cycle (0 cycles when bypassing into an empty queue).
// Backpressure: if_ready drops when both entries are full; fetch words are discarded during a redirect.
module if_id_queue (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] if_inst,
    input  logic [7:0] if_pc,
    input  logic       if_valid,
    output logic       if_ready,
    input  logic       id_ready,
    output logic       id_valid,
    output logic [3:0] id_opcode,
    output logic [1:0] id_ra,
    output logic [1:0] id_rb,
    output logic [7:0] id_pc,
    output logic [7:0] pcj_mux,
    output logic       choice_mux,
    output logic [1:0] count
);

    logic [7:0] r_inst [2];
    logic [7:0] r_pc   [2];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;
    logic       r_choice;
    logic [7:0] r_pcj;

    logic       w_bypass;
    logic       w_id_valid;
    logic [7:0] w_head_inst;
    logic [7:0] w_head_pc;
    logic       w_read;
    logic       w_pop;
    logic       w_jmp_read;
    logic       w_discard;
    logic       w_write;
    logic [7:0] w_target;

`ifdef IFID_BYPASS_EN
    // Fetch word is shown directly only when nothing is stored and no redirect is draining.
    assign w_bypass = (r_count == 2'd0) && if_valid && !r_choice;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_id_valid  = (r_count != 2'd0) || w_bypass;
    assign w_head_inst = w_bypass ? if_inst : r_inst[r_rptr];
    assign w_head_pc   = w_bypass ? if_pc   : r_pc[r_rptr];

    assign w_read     = w_id_valid && id_ready;
    assign w_pop      = w_read && !w_bypass;
    assign w_jmp_read = w_read && (w_head_inst[7:4] == 4'hF);
    assign w_discard  = w_jmp_read || r_choice;
    assign w_write    = if_valid && if_ready && !w_discard && !(w_bypass && id_ready);
    assign w_target   = w_head_pc + {{4{w_head_inst[3]}}, w_head_inst[3:0]};

    assign if_ready   = (r_count < 2'd2);
    assign id_valid   = w_id_valid;
    assign id_opcode  = w_id_valid ? w_head_inst[7:4] : 4'h0;
    assign id_ra      = w_id_valid ? w_head_inst[3:2] : 2'h0;
    assign id_rb      = w_id_valid ? w_head_inst[1:0] : 2'h0;
    assign id_pc      = w_id_valid ? w_head_pc        : 8'h00;
    assign pcj_mux    = r_pcj;
    assign choice_mux = r_choice;
    assign count      = r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_inst[0] <= 8'h00;
            r_inst[1] <= 8'h00;
            r_pc[0]   <= 8'h00;
            r_pc[1]   <= 8'h00;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_count   <= 2'd0;
            r_choice  <= 1'b0;
            r_pcj     <= 8'h00;
        end else begin
            r_choice <= w_jmp_read;
            if (w_jmp_read) begin
                // Redirect flushes everything fetched down the wrong path.
                r_pcj   <= w_target;
                r_count <= 2'd0;
                r_wptr  <= 1'b0;
                r_rptr  <= 1'b0;
            end else begin
                if (w_write) begin
                    r_inst[r_wptr] <= if_inst;
                    r_pc[r_wptr]   <= if_pc;
                    r_wptr         <= ~r_wptr;
                end
                if (w_pop) begin
                    r_rptr <= ~r_rptr;
                end
                case ({w_write, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clock  in  1  rising-edge clock shared with the fetch stage.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 if_inst  in  8  instruction from the fetch stage.
REQ-005 if_pc  in  8  address of if_inst.
REQ-006 if_valid  in  1  if_inst/if_pc are valid this cycle.
REQ-007 if_ready  out  1  queue can accept a word this cycle; used as the fetch stall.
REQ-008 id_ready  in  1  downstream accepts the head entry this cycle.
REQ-009 id_valid  out  1  head entry valid.
REQ-010 id_opcode  out  4  head inst[7:4].
REQ-011 id_ra  out  2  head inst[3:2].
REQ-012 id_rb  out  2  head inst[1:0].
REQ-013 id_pc  out  8  head address.
REQ-014 pcj_mux  out  8  jump target to the fetch PC mux.
REQ-015 choice_mux  out  1  select jump target in the fetch PC mux.
REQ-016 count  out  2  occupancy, 0..2.

Function
REQ-017 Storage SHALL be a 2-entry FIFO of {inst, pc}; write = if_valid && if_ready && !discard, read = id_valid && id_ready.
REQ-018 if_ready SHALL be 1 when count < 2, else 0; no write while full, even with a simultaneous read.
REQ-019 count SHALL update each cycle: +1 on write only, -1 on read only, unchanged on read+write, never above 2 or below 0.
REQ-020 Entries SHALL leave in arrival order; the read/write pointers are 1 bit and wrap 1->0.
REQ-021 id_opcode, id_ra, id_rb and id_pc SHALL come combinationally from the head entry when id_valid=1 and SHALL be 0 when id_valid=0.
REQ-022 JMP is opcode 4'hF; jump target = head pc + sign-extended inst[3:0], 8-bit, modulo 256.
REQ-023 On a read of a JMP, the next edge SHALL set choice_mux=1 and pcj_mux=target for exactly one cycle, then choice_mux=0; pcj_mux holds its value.
REQ-024 On a read of a JMP, the same edge SHALL flush the queue: count=0, pointers=0.
REQ-025 discard SHALL be 1 in the JMP-read cycle and in the cycle choice_mux=1; those fetch words are dropped and if_ready does not change.
REQ-026 Non-JMP opcodes SHALL pass through with no side effects.
REQ-027 Without bypass, latency from write to id_valid SHALL be 1 cycle.

Reset
REQ-028 While reset_n=0: count=0, pointers=0, id_valid=0, all id_* fields=0, choice_mux=0, pcj_mux=0, if_ready=1.
REQ-029 Reset asserted mid-operation SHALL drop all entries and any pending redirect immediately; the first write is accepted on the first edge after release.

Configuration
REQ-030 Macro IFID_BYPASS_EN: when defined and count=0, a non-discarded if_valid word SHALL appear on id_* with id_valid=1 in the same cycle; if id_ready=1 it is consumed without being stored, and count stays 0.
REQ-031 Without IFID_BYPASS_EN, id_valid SHALL depend only on stored entries, with a fixed 1-cycle latency.

Verification
REQ-032 Reset, then write inst 8'h12 pc 8'h00 with id_ready=0 -> next cycle: id_valid=1, opcode=1, ra=0, rb=2, id_pc=0, count=1.
REQ-033 Write 8'h21 then 8'h34 with id_ready=0 -> count=2, if_ready=0; a third write of 8'h56 is ignored; drain -> 8'h21 then 8'h34 appear, count returns to 0.
REQ-034 Head JMP 8'hF3 at pc 8'h10 is read -> next cycle: choice_mux=1, pcj_mux=8'h13, count=0; one cycle later choice_mux=0.
REQ-035 Head JMP 8'hFE at pc 8'h01 -> pcj_mux=8'hFF (wrap); the fetch word in the read cycle and in the choice_mux cycle is not stored.
REQ-036 count=1, write and read in the same cycle -> count stays 1; FIFO order is preserved.
REQ-037 reset_n=0 pulsed mid-cycle with count=2 and choice_mux=1 -> all outputs reach reset values without waiting for a clock edge; with IFID_BYPASS_EN defined, 8'h12 written to an empty queue -> id_valid=1 in the same cycle.
